// File: rtl/tx_pkt_fifo_pkg.sv
// Shared beat format, write-FSM state type and default depth for the TX packet buffer.
package tx_pkt_fifo_pkg;

    localparam int N_SYMBOLS     = 8;
    localparam int W_SYMBOL      = 8;
    localparam int TX_FIFO_DEPTH = 512;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic                                 last;
        logic [N_SYMBOLS-1:0]                 keep;
        logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]   data;
    } beat_t;

    localparam int W_BEAT = $bits(beat_t);

endpackage

// File: rtl/tx_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; caller owns address and occupancy tracking.
module tx_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tx_pkt_fifo.sv
// Store-and-forward TX frame buffer; only fully stored frames are released to the MAC.
// Latency: tvalid rises two cycles after the committing tlast beat (empty output stage).
// Backpressure: never stalls the input; overflowing or tuser-flagged frames are dropped whole.
module tx_pkt_fifo
    import tx_pkt_fifo_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH
) (
    input  logic                                 i_tx_clk,
    input  logic                                 i_tx_reset_n,
    input  logic                                 s_axis_tvalid,
    input  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]   s_axis_tdata,
    input  logic [N_SYMBOLS-1:0]                 s_axis_tkeep,
    input  logic                                 s_axis_tlast,
    input  logic                                 s_axis_tuser,
    output logic                                 s_axis_tready,
    output logic                                 m_axis_tvalid,
    output logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]   m_axis_tdata,
    output logic [N_SYMBOLS-1:0]                 m_axis_tkeep,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    output logic                                 o_frame_drop,
    output logic [$clog2(DEPTH):0]               o_frame_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

    wr_state_t   state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] commit_q, commit_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] frame_cnt_q;
    logic        drop_q, drop_d;
    logic        commit_evt;
    logic        ram_we;
    logic        acc;
    logic        full;

    beat_t              wr_beat;
    beat_t              rd_beat;
    logic [W_BEAT-1:0]  rd_dat;
    beat_t              h_q, s_q;
    logic               h_vld, s_vld;
    logic               rd_pend;
    logic               rd_en;
    logic               avail;
    logic               pop;
    logic               dec;
    logic [1:0]         inflight;

    assign s_axis_tready = i_tx_reset_n;
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign full          = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign wr_beat       = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        commit_d   = commit_q;
        drop_d     = 1'b0;
        ram_we     = 1'b0;
        commit_evt = 1'b0;
        if (acc) begin
            case (state_q)
                WR_IDLE, WR_DATA: begin
                    if (!full) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (s_axis_tlast) begin
                            if (s_axis_tuser) begin
                                wr_ptr_d = commit_q;
                                drop_d   = 1'b1;
                            end else begin
                                commit_d   = wr_ptr_q + PTR_ONE;
                                commit_evt = 1'b1;
                            end
                            state_d = WR_IDLE;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end else begin
                        // No room: rewind to the last frame boundary and swallow the rest.
                        wr_ptr_d = commit_q;
                        if (s_axis_tlast) begin
                            drop_d  = 1'b1;
                            state_d = WR_IDLE;
                        end else begin
                            state_d = WR_DROP;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) begin
                        drop_d  = 1'b1;
                        state_d = WR_IDLE;
                    end
                end
                default: state_d = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_tx_clk) begin
        if (!i_tx_reset_n) begin
            state_q  <= WR_IDLE;
            wr_ptr_q <= '0;
            commit_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            commit_q <= commit_d;
            drop_q   <= drop_d;
        end
    end

    tx_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (W_BEAT)
    ) u_ram (
        .clk     (i_tx_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_dat  (wr_beat),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_dat  (rd_dat)
    );

    assign rd_beat  = rd_dat;
    assign avail    = rd_ptr_q != commit_q;
    assign pop      = h_vld && m_axis_tready;
    assign dec      = pop && h_q.last;
    assign inflight = {1'b0, h_vld} + {1'b0, s_vld} + {1'b0, rd_pend};
    // Two output slots; a read may issue only if its beat will find a free slot on arrival.
    assign rd_en    = avail && ((inflight < 2'd2) || ((inflight == 2'd2) && pop));

    always_ff @(posedge i_tx_clk) begin
        if (!i_tx_reset_n) begin
            rd_ptr_q <= '0;
            rd_pend  <= 1'b0;
            h_vld    <= 1'b0;
            s_vld    <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (pop || !h_vld) begin
                h_vld <= s_vld || rd_pend;
                s_vld <= s_vld && rd_pend;
            end else if (rd_pend) begin
                s_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_tx_clk) begin
        if (pop || !h_vld) begin
            if (s_vld) begin
                h_q <= s_q;
            end else if (rd_pend) begin
                h_q <= rd_beat;
            end
            if (s_vld && rd_pend) begin
                s_q <= rd_beat;
            end
        end else if (rd_pend) begin
            s_q <= rd_beat;
        end
    end

    always_ff @(posedge i_tx_clk) begin
        if (!i_tx_reset_n) begin
            frame_cnt_q <= '0;
        end else begin
            case ({commit_evt, dec})
                2'b10:   frame_cnt_q <= frame_cnt_q + PTR_ONE;
                2'b01:   frame_cnt_q <= frame_cnt_q - PTR_ONE;
                default: frame_cnt_q <= frame_cnt_q;
            endcase
        end
    end

    assign m_axis_tvalid = h_vld;
    assign m_axis_tdata  = h_q.data;
    assign m_axis_tkeep  = h_q.keep;
    assign m_axis_tlast  = h_q.last;
    assign o_frame_drop  = drop_q;
    assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_tx_pkt_fifo.sv
// Directed bench for tx_pkt_fifo at DEPTH=16: commit latency, drops, exact fit, stalls, reset.
module tb_tx_pkt_fifo;
    import tx_pkt_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic                               s_axis_tvalid;
    logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] s_axis_tdata;
    logic [N_SYMBOLS-1:0]               s_axis_tkeep;
    logic                               s_axis_tlast;
    logic                               s_axis_tuser;
    logic                               s_axis_tready;
    logic                               m_axis_tvalid;
    logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] m_axis_tdata;
    logic [N_SYMBOLS-1:0]               m_axis_tkeep;
    logic                               m_axis_tlast;
    logic                               m_axis_tready;
    logic                               o_frame_drop;
    logic [$clog2(DEPTH):0]             o_frame_count;

    always #5 clk = ~clk;

    tx_pkt_fifo #(.DEPTH(DEPTH)) dut (
        .i_tx_clk      (clk),
        .i_tx_reset_n  (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .o_frame_drop  (o_frame_drop),
        .o_frame_count (o_frame_count)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];
    int    cnt_hist[$];
    int    drop_cnt = 0;
    int    gap_err  = 0;
    int    stab_err = 0;
    logic  in_frame = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;

    // Observer on the falling edge: records handshakes, drop pulses, mid-frame gaps, stall stability.
    always @(negedge clk) begin
        beat_t cur;
        cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (!rst_n) begin
            in_frame   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (in_frame && !m_axis_tvalid) gap_err++;
            if (prev_stall && (cur !== prev_beat)) stab_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                obs_q.push_back(cur);
                in_frame = !m_axis_tlast;
            end
            if (o_frame_drop) drop_cnt++;
            cnt_hist.push_back(int'(o_frame_count));
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int n, input logic [63:0] base, input logic [7:0] last_keep);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.last = (i == n - 1);
            b.keep = (i == n - 1) ? last_keep : 8'hFF;
            b.data = base + 64'(i);
            exp_q.push_back(b);
        end
    endtask

    // Drives n back-to-back beats; returns 1 time unit after the edge that accepts tlast.
    task automatic send_frame(input int n, input logic [63:0] base, input logic [7:0] last_keep,
                              input logic bad);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 64'(i);
            s_axis_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
            s_axis_tlast  = (i == n - 1);
            s_axis_tuser  = bad && (i == n - 1);
            tick(1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; m_axis_tready = 1'b0;
        tick(3);
        n_checks++;
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_checks++;
        if (o_frame_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_frame_count); end
        n_checks++;
        if (o_frame_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", o_frame_drop); end
        rst_n = 1'b1;
        tick(1);
        n_checks++;
        if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL run_tready: got %b want 1", s_axis_tready); end
    endtask

    task automatic test_single_frame;
        int ob;
        ob = obs_q.size();
        exp_q.delete();
        push_exp(4, 64'h1, 8'h0F);
        m_axis_tready = 1'b1;
        send_frame(4, 64'h1, 8'h0F, 1'b0);
        n_checks++;
        if (o_frame_count !== 5'd1) begin n_fail++; $display("FAIL single_count_commit: got %0d want 1", o_frame_count); end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_lat_t0: got %b want 0", m_axis_tvalid); end
        tick(1);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_lat_t1: got %b want 0", m_axis_tvalid); end
        tick(1);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h1) begin
            n_fail++; $display("FAIL single_lat_t2: got vld %b data %h want 1 / 1", m_axis_tvalid, m_axis_tdata);
        end
        tick(6);
        n_checks++;
        if (o_frame_count !== '0) begin n_fail++; $display("FAIL single_count_end: got %0d want 0", o_frame_count); end
        n_checks++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            n_fail++; $display("FAIL single_beats: got %0d want %0d", obs_q.size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[ob+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single_beat%0d: got %h want %h", i, obs_q[ob+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bad_frame;
        int ob, d0;
        ob = obs_q.size();
        d0 = drop_cnt;
        exp_q.delete();
        push_exp(2, 64'h20, 8'h03);
        send_frame(3, 64'h10, 8'hFF, 1'b1);
        n_checks++;
        if (o_frame_drop !== 1'b1) begin n_fail++; $display("FAIL bad_drop_pulse: got %b want 1", o_frame_drop); end
        tick(1);
        n_checks++;
        if (o_frame_drop !== 1'b0) begin n_fail++; $display("FAIL bad_drop_width: got %b want 0", o_frame_drop); end
        n_checks++;
        if (o_frame_count !== '0) begin n_fail++; $display("FAIL bad_count: got %0d want 0", o_frame_count); end
        send_frame(2, 64'h20, 8'h03, 1'b0);
        tick(8);
        n_checks++;
        if (drop_cnt - d0 !== 1) begin n_fail++; $display("FAIL bad_drop_total: got %0d want 1", drop_cnt - d0); end
        n_checks++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            n_fail++; $display("FAIL bad_beats: got %0d want %0d", obs_q.size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[ob+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bad_beat%0d: got %h want %h", i, obs_q[ob+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_oversize;
        int ob, d0;
        ob = obs_q.size();
        d0 = drop_cnt;
        exp_q.delete();
        push_exp(3, 64'h200, 8'h07);
        m_axis_tready = 1'b0;
        send_frame(20, 64'h100, 8'hFF, 1'b0);
        n_checks++;
        if (o_frame_drop !== 1'b1) begin n_fail++; $display("FAIL over_drop_pulse: got %b want 1", o_frame_drop); end
        n_checks++;
        if (o_frame_count !== '0) begin n_fail++; $display("FAIL over_count: got %0d want 0", o_frame_count); end
        tick(2);
        m_axis_tready = 1'b1;
        send_frame(3, 64'h200, 8'h07, 1'b0);
        tick(8);
        n_checks++;
        if (drop_cnt - d0 !== 1) begin n_fail++; $display("FAIL over_drop_total: got %0d want 1", drop_cnt - d0); end
        n_checks++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            n_fail++; $display("FAIL over_beats: got %0d want %0d", obs_q.size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[ob+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL over_beat%0d: got %h want %h", i, obs_q[ob+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_exact_fit;
        int ob, d0;
        ob = obs_q.size();
        d0 = drop_cnt;
        exp_q.delete();
        push_exp(16, 64'h300, 8'h01);
        m_axis_tready = 1'b1;
        send_frame(16, 64'h300, 8'h01, 1'b0);
        tick(22);
        n_checks++;
        if (drop_cnt - d0 !== 0) begin n_fail++; $display("FAIL fit16_drop: got %0d want 0", drop_cnt - d0); end
        n_checks++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            n_fail++; $display("FAIL fit16_beats: got %0d want %0d", obs_q.size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[ob+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL fit16_beat%0d: got %h want %h", i, obs_q[ob+i], exp_q[i]);
            end
        end
        ob = obs_q.size();
        d0 = drop_cnt;
        send_frame(17, 64'h400, 8'hFF, 1'b0);
        n_checks++;
        if (o_frame_drop !== 1'b1) begin n_fail++; $display("FAIL fit17_drop_pulse: got %b want 1", o_frame_drop); end
        tick(22);
        n_checks++;
        if (drop_cnt - d0 !== 1) begin n_fail++; $display("FAIL fit17_drop_total: got %0d want 1", drop_cnt - d0); end
        n_checks++;
        if (obs_q.size() - ob !== 0) begin n_fail++; $display("FAIL fit17_beats: got %0d want 0", obs_q.size() - ob); end
    endtask

    task automatic test_back_to_back;
        int ob, hb, g0, s0, peak;
        ob = obs_q.size();
        hb = cnt_hist.size();
        g0 = gap_err;
        s0 = stab_err;
        exp_q.delete();
        push_exp(5, 64'h500, 8'h3F);
        push_exp(5, 64'h510, 8'h3F);
        push_exp(5, 64'h520, 8'h3F);
        fork
            begin
                send_frame(5, 64'h500, 8'h3F, 1'b0);
                send_frame(5, 64'h510, 8'h3F, 1'b0);
                send_frame(5, 64'h520, 8'h3F, 1'b0);
            end
            begin
                m_axis_tready = 1'b0;
                tick(15);
                repeat (60) begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                    tick(1);
                end
                m_axis_tready = 1'b1;
            end
        join
        tick(25);
        peak = 0;
        for (int i = hb; i < cnt_hist.size(); i++) if (cnt_hist[i] > peak) peak = cnt_hist[i];
        n_checks++;
        if (peak !== 3) begin n_fail++; $display("FAIL b2b_count_peak: got %0d want 3", peak); end
        n_checks++;
        if (gap_err - g0 !== 0) begin n_fail++; $display("FAIL b2b_midframe_gap: got %0d want 0", gap_err - g0); end
        n_checks++;
        if (stab_err - s0 !== 0) begin n_fail++; $display("FAIL b2b_stall_stable: got %0d want 0", stab_err - s0); end
        n_checks++;
        if (o_frame_count !== '0) begin n_fail++; $display("FAIL b2b_count_end: got %0d want 0", o_frame_count); end
        n_checks++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b_beats: got %0d want %0d", obs_q.size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[ob+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_beat%0d: got %h want %h", i, obs_q[ob+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int ob, k;
        m_axis_tready = 1'b1;
        send_frame(6, 64'h600, 8'hFF, 1'b0);
        k = 0;
        while (!m_axis_tvalid && k < 10) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_wait_valid: got %b want 1", m_axis_tvalid); end
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tvalid: got %b want 0", m_axis_tvalid); end
        n_checks++;
        if (o_frame_count !== '0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", o_frame_count); end
        ob = obs_q.size();
        tick(15);
        n_checks++;
        if (obs_q.size() - ob !== 0) begin n_fail++; $display("FAIL rmid_stale_beats: got %0d want 0", obs_q.size() - ob); end
        exp_q.delete();
        push_exp(2, 64'h700, 8'h0F);
        send_frame(2, 64'h700, 8'h0F, 1'b0);
        tick(8);
        n_checks++;
        if (obs_q.size() - ob !== exp_q.size()) begin
            n_fail++; $display("FAIL rmid_beats: got %0d want %0d", obs_q.size() - ob, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[ob+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rmid_beat%0d: got %h want %h", i, obs_q[ob+i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bad_frame();
        test_oversize();
        test_exact_fit();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/tx_pkt_fifo.md
# tx_pkt_fifo

Store-and-forward AXI-Stream packet buffer on the TX path. It sits directly upstream of the MAC/PCS core's `s_axis` input in the `i_tx_clk` domain. A frame is released to the MAC only once it is fully stored, so the MAC never sees a mid-frame `tvalid` gap (underrun). Oversized frames and frames flagged bad on `tuser` are dropped whole, with a status pulse.

## Interface
Parameters:
- `DEPTH`, 512: buffer depth in beats; must be a power of 2, minimum 16.
- Beat format comes from `cmn_params`: `N_SYMBOLS` byte lanes of `W_SYMBOL` bits. No local override.

Ports:
- `i_tx_clk`, in, 1: clock.
- `i_tx_reset_n`, in, 1: synchronous, active-low reset.
- `s_axis_tvalid`, in, 1: input beat valid.
- `s_axis_tdata`, in, `[N_SYMBOLS-1:0][W_SYMBOL-1:0]`: input data.
- `s_axis_tkeep`, in, `N_SYMBOLS`: byte enables; stored and forwarded unchanged.
- `s_axis_tlast`, in, 1: last beat of frame.
- `s_axis_tuser`, in, 1: sampled on the `tlast` beat only; 1 = drop the frame.
- `s_axis_tready`, out, 1: 0 in reset, 1 otherwise. The block never backpressures.
- `m_axis_tvalid`, out, 1: output beat valid, to the MAC.
- `m_axis_tdata`, out, `[N_SYMBOLS-1:0][W_SYMBOL-1:0]`: output data.
- `m_axis_tkeep`, out, `N_SYMBOLS`: output byte enables.
- `m_axis_tlast`, out, 1: last beat of output frame.
- `m_axis_tready`, in, 1: MAC ready.
- `o_frame_drop`, out, 1: one-cycle pulse per dropped frame.
- `o_frame_count`, out, `$clog2(DEPTH)+1`: committed frames not yet fully read.

## Operation
- Pointers are `AW+1` bits wide, where `AW = $clog2(DEPTH)`:
  - `wr_ptr`: speculative write pointer.
  - `commit_ptr`: end of the last complete frame.
  - `rd_ptr`: read pointer.
- `full` is `wr_ptr - rd_ptr == DEPTH`, computed from registered pointers. Space freed by a read becomes usable the next cycle.
- Write FSM, states `WR_IDLE`, `WR_DATA`, `WR_DROP`. An accepted beat is `s_axis_tvalid && s_axis_tready`.
  - `WR_IDLE`/`WR_DATA`, not full: write `{tlast, tkeep, tdata}` at `wr_ptr`, then `wr_ptr++`.
    - `tlast && !tuser`: `commit_ptr <= wr_ptr+1`, go to `WR_IDLE`.
    - `tlast && tuser`: `wr_ptr <= commit_ptr`, pulse drop, go to `WR_IDLE`.
    - Otherwise go to `WR_DATA`.
  - `WR_IDLE`/`WR_DATA`, full: discard the beat, `wr_ptr <= commit_ptr`.
    - `tlast`: pulse drop, go to `WR_IDLE`.
    - Otherwise go to `WR_DROP`.
  - `WR_DROP`: discard all beats; on `tlast`, pulse drop and go to `WR_IDLE`.
- Read side:
  - Data is available when `rd_ptr != commit_ptr`.
  - The read side is a synchronous RAM read feeding an output stage that is at least 2 deep, giving full rate with registered `m_axis_*`.
  - Because only whole frames are readable, `m_axis_tvalid` stays high from a frame's first beat through its `tlast` beat.
- `o_frame_count`:
  - `+1` on commit.
  - `-1` on an `m_axis_tvalid && m_axis_tready && m_axis_tlast` handshake.
  - Both in the same cycle: unchanged.
- Reset values: all pointers 0, FSM `WR_IDLE`, `m_axis_tvalid` 0, `o_frame_drop` 0, `o_frame_count` 0, `s_axis_tready` 0. RAM contents are don't-care.
- Reset mid-operation: stored and in-flight frames are discarded and not emitted. The first accepted beat after reset starts a new frame.

## Timing
- `tlast` beat accepted at edge t, output stage empty: `m_axis_tvalid` rises at t+2.
- Throughput: 1 beat/cycle in and out, sustained.
- `o_frame_drop` is registered and high for exactly the cycle after the beat that terminates the drop.
- An `m_axis_*` payload is stable while `tvalid && !tready`.

## Structure
- `mac_params`: `TX_FIFO_DEPTH` default constant, `wr_state_t` enum.
- Sub-module `tx_fifo_ram`: simple dual-port synchronous RAM, one write port, one read port, 1-cycle read latency, width `N_SYMBOLS*W_SYMBOL + N_SYMBOLS + 1`.

## Test plan
All scenarios use `DEPTH`=16.
- 4-beat frame, data 0x1..0x4, last-beat `tkeep`=0x0F, `m_axis_tready`=1 -> identical 4 beats start 2 cycles after `tlast`; `o_frame_count` goes 0→1→0.
- 3-beat frame with `tuser`=1 on `tlast`, then a 2-beat good frame -> no bad frame output; `o_frame_drop` pulses once; the good frame is output intact.
- 20-beat frame with `m_axis_tready`=0 -> dropped; one drop pulse the cycle after beat 20; count stays 0. A following 3-beat frame is output.
- Exact fit: a 16-beat frame into an empty buffer -> committed and output. A 17-beat frame into an empty buffer -> dropped.
- Three 5-beat frames with `m_axis_tready` randomly toggled -> order and content exact; `tvalid` never drops mid-frame; count peaks at 3.
- `i_tx_reset_n`=0 for 1 cycle mid-output -> next cycle `m_axis_tvalid`=0 and count=0; no pre-reset beats appear afterward.
